dff_wr_arbiter: RTL and testbench

- Round-robin write arbiter and sequencer for one shared Width-bit storage register (the team's dff).
- NumReq requesters offer data over valid/ready; the block grants one at a time, writes its data into the register, then holds the value for a programmable window before re-arbitrating.
- Sits between requester logic and the shared register; reg_o is the register output seen by consumers.

---
 rtl/dff_wr_arbiter.sv | 119 +++++++++++
 tb/tb_dff_wr_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dff_wr_arbiter.sv
// rtl/dff_wr_arbiter.sv - round-robin write arbiter/sequencer for one shared register.
// Define DFF_WR_ARBITER_FIXED_PRIO_EN for fixed priority (lowest valid index wins).
module dff_wr_arbiter #(
  parameter int Width      = 4,
  parameter int NumReq     = 4,
  parameter int HoldCycles = 2,
  localparam int OwnerW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq*Width-1:0] req_data_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic [Width-1:0]        reg_o,
  output logic [OwnerW-1:0]       owner_o,
  output logic                    upd_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_e;

  state_e              state_q;
  logic [OwnerW-1:0]   grant_q;
  logic [OwnerW-1:0]   owner_q;
  logic [Width-1:0]    reg_q;
  logic [NumReq-1:0]   ready_q;
  logic [7:0]          cnt_q;
  logic                upd_q;
  logic [OwnerW-1:0]   ptr;
  logic [OwnerW-1:0]   ptr_d;
  logic [OwnerW-1:0]   win;
  logic                found;

`ifdef DFF_WR_ARBITER_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [OwnerW-1:0] ptr_q;
  assign ptr = ptr_q;
`endif

  // Scan ptr, ptr+1, ... modulo NumReq; first valid index wins.
  always_comb begin
    int idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NumReq; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = OwnerW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = '0;
    if (int'(grant_q) != NumReq - 1) ptr_d = grant_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      reg_q   <= '0;
      ready_q <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
`ifndef DFF_WR_ARBITER_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          upd_q <= 1'b0;
          if (found) begin
            grant_q <= win;
            ready_q <= {{(NumReq-1){1'b0}}, 1'b1} << win;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          ready_q <= '0;
          if (req_valid_i[grant_q]) begin
            reg_q   <= req_data_i[grant_q*Width +: Width];
            owner_q <= grant_q;
            upd_q   <= 1'b1;
            cnt_q   <= 8'(HoldCycles);
            state_q <= HOLD;
`ifndef DFF_WR_ARBITER_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          upd_q <= 1'b0;
          cnt_q <= (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
          if (cnt_q <= 8'd1) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= '0;
          upd_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign reg_o       = reg_q;
  assign owner_o     = owner_q;
  assign upd_o       = upd_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dff_wr_arbiter.sv
// tb/tb_dff_wr_arbiter.sv - directed self-checking bench for dff_wr_arbiter.
module tb_dff_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  valid = 4'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  ready;
  logic [3:0]  regv;
  logic [1:0]  owner;
  logic        upd;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [1:0] fair_own [5];
  logic [3:0] fair_dat [4];
  logic [1:0] o1, o2;
  logic [3:0] r1, r2;

  dff_wr_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_data_i(data),
    .req_ready_o(ready), .reg_o(regv), .owner_o(owner), .upd_o(upd), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef DFF_WR_ARBITER_FIXED_PRIO_EN
    fair_own = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    o1 = 2'd0; o2 = 2'd0; r1 = 4'h1; r2 = 4'h1;
`else
    fair_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    o1 = 2'd2; o2 = 2'd3; r1 = 4'hB; r2 = 4'hD;
`endif
    fair_dat = '{4'h5, 4'h9, 4'h2, 4'h6};

    // Reset with all requesters valid
    valid = 4'b1111;
    tick(); tick();
    chk("rst_reg", regv, 4'h0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_ready", ready, 4'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_upd", upd, 1'b0);

    valid = 4'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy", busy, 1'b0);
    end

    // Fairness: all valid, held continuously
    data = {4'h6, 4'h2, 4'h9, 4'h5};
    valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fair_ready", ready, 4'b0001 << fair_own[k]);
      chk("fair_busy_w", busy, 1'b1);
      tick();
      chk("fair_owner", owner, fair_own[k]);
      chk("fair_reg", regv, fair_dat[fair_own[k]]);
      chk("fair_upd", upd, 1'b1);
      chk("fair_ready_h", ready, 4'b0);
      tick();
      chk("fair_upd_h2", upd, 1'b0);
      chk("fair_busy_h2", busy, 1'b1);
      tick();
      chk("fair_busy_idle", busy, 1'b0);
    end
    valid = 4'b0;
    tick();
    chk("fair_stop_busy", busy, 1'b0);

    // Single write from requester 2
    data = {4'h0, 4'h7, 4'h0, 4'h0};
    valid = 4'b0100;
    tick();
    chk("single_ready", ready, 4'b0100);
    chk("single_busy_w", busy, 1'b1);
    chk("single_reg_pre", regv, fair_dat[fair_own[4]]);
    tick();
    valid = 4'b0;
    chk("single_reg", regv, 4'h7);
    chk("single_owner", owner, 2'd2);
    chk("single_upd", upd, 1'b1);
    chk("single_ready_off", ready, 4'b0);
    tick();
    chk("single_upd_off", upd, 1'b0);
    chk("single_busy_h2", busy, 1'b1);
    tick();
    chk("single_busy_end", busy, 1'b0);

    // Wrap and skip: only requester 1 valid
    data = {4'h0, 4'h0, 4'hA, 4'h0};
    valid = 4'b0010;
    tick();
    chk("wrap_ready", ready, 4'b0010);
    tick();
    valid = 4'b0;
    chk("wrap_owner", owner, 2'd1);
    chk("wrap_reg", regv, 4'hA);
    tick(); tick();

    // Requesters 0,2,3 valid: round-robin resumes at 2
    data = {4'hD, 4'hB, 4'h0, 4'h1};
    valid = 4'b1101;
    tick(); tick();
    chk("ptr_owner1", owner, o1);
    chk("ptr_reg1", regv, r1);
    tick(); tick();
    tick(); tick();
    valid = 4'b0;
    chk("ptr_owner2", owner, o2);
    chk("ptr_reg2", regv, r2);
    tick(); tick();

    // Withdrawal during WRITE
    data = {4'h0, 4'h0, 4'h0, 4'hC};
    valid = 4'b0001;
    tick();
    chk("wd_ready", ready, 4'b0001);
    valid = 4'b0;
    tick();
    chk("wd_reg", regv, r2);
    chk("wd_upd", upd, 1'b0);
    chk("wd_busy", busy, 1'b0);
    chk("wd_ready_off", ready, 4'b0);

    data = {4'h8, 4'h0, 4'h0, 4'h3};
    valid = 4'b1001;
    tick();
    chk("wd_regrant", ready, 4'b0001);
    tick();
    valid = 4'b0;
    chk("wd_owner", owner, 2'd0);
    chk("wd_reg3", regv, 4'h3);

    // Async reset in the middle of HOLD
    tick();
    chk("hold_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_reg", regv, 4'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_owner", owner, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
